// File: rtl/atm_pkg.sv
// Shared state encoding, opcodes and per-account reset-value helpers for the ATM session controller.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package atm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAITING = 3'd1,
        ST_AUTH    = 3'd2,
        ST_MENU    = 3'd3,
        ST_EXEC    = 3'd4
    } state_t;

    localparam logic [2:0] OP_BALANCE    = 3'd0;
    localparam logic [2:0] OP_WITHDRAW   = 3'd1;
    localparam logic [2:0] OP_DEPOSIT    = 3'd2;
    localparam logic [2:0] OP_CHANGE_PIN = 3'd3;
    localparam logic [2:0] OP_TRANSFER   = 3'd4;
    localparam logic [2:0] OP_LOGOUT     = 3'd5;

    // Opcodes 6 and 7 are unassigned.
    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_LOGOUT;
    endfunction

    // Returned wide; callers truncate to their own BAL_W / PIN_W.
    function automatic logic [63:0] reset_balance(input int idx);
        return (64'(idx) + 64'd1) * 64'd1000;
    endfunction

    function automatic logic [63:0] reset_pin(input int idx);
        return 64'(idx) * 64'd1111;
    endfunction

endpackage

// File: rtl/atm_account_store.sv
// Per-account storage: balances, PINs, consecutive-failure counters and lock bits.
// Latency: writes land on the clock edge; every account is readable combinationally.
// Backpressure: none; two balance write entries per cycle so a transfer updates both sides together.
// Ports: rd_bal/rd_pin/rd_lock expose every account; wr0/wr1 write balances, pin_wr writes a PIN,
//        auth_ok/auth_fail with auth_idx clear or advance the failure counter of one account.
module atm_account_store
    import atm_pkg::*;
#(
    parameter int NUM_ACC   = 16,
    parameter int BAL_W     = 32,
    parameter int PIN_W     = 16,
    parameter int MAX_TRIES = 3,
    parameter int AW        = $clog2(NUM_ACC)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [BAL_W-1:0] rd_bal [NUM_ACC],
    output logic [PIN_W-1:0] rd_pin [NUM_ACC],
    output logic [NUM_ACC-1:0] rd_lock,
    input  logic             wr0_en,
    input  logic [AW-1:0]    wr0_idx,
    input  logic [BAL_W-1:0] wr0_bal,
    input  logic             wr1_en,
    input  logic [AW-1:0]    wr1_idx,
    input  logic [BAL_W-1:0] wr1_bal,
    input  logic             pin_wr_en,
    input  logic [AW-1:0]    pin_wr_idx,
    input  logic [PIN_W-1:0] pin_wr_dat,
    input  logic             auth_ok,
    input  logic             auth_fail,
    input  logic [AW-1:0]    auth_idx
);

    localparam int TW = $clog2(MAX_TRIES + 1);

    logic [TW-1:0] tries [NUM_ACC];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                rd_bal[i]  <= BAL_W'(reset_balance(i));
                rd_pin[i]  <= PIN_W'(reset_pin(i));
                tries[i]   <= '0;
                rd_lock[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_ACC; i++) begin
                if (wr0_en && wr0_idx == AW'(i)) rd_bal[i] <= wr0_bal;
                if (wr1_en && wr1_idx == AW'(i)) rd_bal[i] <= wr1_bal;
                if (pin_wr_en && pin_wr_idx == AW'(i)) rd_pin[i] <= pin_wr_dat;
                if (auth_idx == AW'(i)) begin
                    if (auth_ok) begin
                        tries[i] <= '0;
                    end else if (auth_fail && !rd_lock[i]) begin
                        // A locked account stops counting; the lock holds until reset.
                        tries[i] <= tries[i] + 1'b1;
                        if (32'(tries[i]) + 1 >= MAX_TRIES) rd_lock[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session FSM: card insert, PIN check with lockout, menu operations and idle timeout.
// Latency: auth result 2 cycles after start, operation result 2 cycles after op_valid; done/success registered.
// Backpressure: none; strobes outside the state that accepts them are dropped.
// Ports: start/acc_num/pin insert a card; op_valid/operation/amount/dest_acc/new_pin request an operation;
//        balance/done/success/locked/state report the session.
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int NUM_ACC   = 16,
    parameter int BAL_W     = 32,
    parameter int PIN_W     = 16,
    parameter int MAX_TRIES = 3,
    parameter int TIMEOUT   = 255,
    parameter int AW        = $clog2(NUM_ACC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    acc_num,
    input  logic [PIN_W-1:0] pin,
    input  logic             op_valid,
    input  logic [2:0]       operation,
    input  logic [BAL_W-1:0] amount,
    input  logic [AW-1:0]    dest_acc,
    input  logic [PIN_W-1:0] new_pin,
    output logic [BAL_W-1:0] balance,
    output logic             done,
    output logic             success,
    output logic             locked,
    output logic [2:0]       state
);

    localparam int IW = $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    sess_q, sess_d;
    logic [AW-1:0]    dest_q;
    logic [PIN_W-1:0] pin_q, new_pin_q;
    logic [2:0]       op_q;
    logic [BAL_W-1:0] amt_q;
    logic [IW-1:0]    idle_q, idle_d;
    logic             done_d, success_d;
    logic [BAL_W-1:0] bal_d;

    logic [BAL_W-1:0] rd_bal [NUM_ACC];
    logic [PIN_W-1:0] rd_pin [NUM_ACC];
    logic [NUM_ACC-1:0] rd_lock;
    logic             wr0_en, wr1_en, pin_wr_en, auth_ok, auth_fail;
    logic [BAL_W-1:0] wr0_bal, wr1_bal;

    logic [BAL_W-1:0] cur_bal, dst_bal;
    logic [BAL_W:0]   dep_sum, xfer_sum;
    logic             start_ok, dest_in_range;

    // With a power-of-two account count every index is valid.
    generate
        if (NUM_ACC == (1 << AW)) begin : g_pow2
            assign start_ok      = 1'b1;
            assign dest_in_range = 1'b1;
        end else begin : g_npow2
            assign start_ok      = (32'(acc_num) < NUM_ACC);
            assign dest_in_range = (32'(dest_q) < NUM_ACC);
        end
    endgenerate

    assign cur_bal  = rd_bal[sess_q];
    assign dst_bal  = rd_bal[dest_q];
    // One extra bit so a carry out means the credit would overflow.
    assign dep_sum  = {1'b0, cur_bal} + {1'b0, amt_q};
    assign xfer_sum = {1'b0, dst_bal} + {1'b0, amt_q};

    atm_account_store #(
        .NUM_ACC  (NUM_ACC),
        .BAL_W    (BAL_W),
        .PIN_W    (PIN_W),
        .MAX_TRIES(MAX_TRIES),
        .AW       (AW)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .rd_bal    (rd_bal),
        .rd_pin    (rd_pin),
        .rd_lock   (rd_lock),
        .wr0_en    (wr0_en),
        .wr0_idx   (sess_q),
        .wr0_bal   (wr0_bal),
        .wr1_en    (wr1_en),
        .wr1_idx   (dest_q),
        .wr1_bal   (wr1_bal),
        .pin_wr_en (pin_wr_en),
        .pin_wr_idx(sess_q),
        .pin_wr_dat(new_pin_q),
        .auth_ok   (auth_ok),
        .auth_fail (auth_fail),
        .auth_idx  (sess_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        sess_d    = sess_q;
        idle_d    = '0;
        done_d    = 1'b0;
        success_d = 1'b0;
        wr0_en    = 1'b0;
        wr0_bal   = cur_bal;
        wr1_en    = 1'b0;
        wr1_bal   = xfer_sum[BAL_W-1:0];
        pin_wr_en = 1'b0;
        auth_ok   = 1'b0;
        auth_fail = 1'b0;
        bal_d     = '0;

        case (state_q)
            ST_IDLE: state_d = ST_WAITING;

            ST_WAITING: begin
                if (start) begin
                    if (start_ok) begin
                        sess_d  = acc_num;
                        state_d = ST_AUTH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            ST_AUTH: begin
                done_d = 1'b1;
                if (!rd_lock[sess_q] && pin_q == rd_pin[sess_q]) begin
                    success_d = 1'b1;
                    auth_ok   = 1'b1;
                    state_d   = ST_MENU;
                end else begin
                    auth_fail = 1'b1;
                    state_d   = ST_WAITING;
                end
            end

            ST_MENU: begin
                if (op_valid) begin
                    if (op_is_legal(operation)) state_d = ST_EXEC;
                    else                        done_d  = 1'b1;
                end else if (32'(idle_q) + 1 >= TIMEOUT) begin
                    state_d = ST_WAITING;
                    done_d  = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end

            ST_EXEC: begin
                done_d  = 1'b1;
                state_d = ST_MENU;
                case (op_q)
                    OP_BALANCE: success_d = 1'b1;
                    OP_WITHDRAW: begin
                        if (amt_q <= cur_bal) begin
                            wr0_en    = 1'b1;
                            wr0_bal   = cur_bal - amt_q;
                            success_d = 1'b1;
                        end
                    end
                    OP_DEPOSIT: begin
                        if (!dep_sum[BAL_W]) begin
                            wr0_en    = 1'b1;
                            wr0_bal   = dep_sum[BAL_W-1:0];
                            success_d = 1'b1;
                        end
                    end
                    OP_CHANGE_PIN: begin
                        pin_wr_en = 1'b1;
                        success_d = 1'b1;
                    end
                    OP_TRANSFER: begin
                        if (dest_in_range && dest_q != sess_q && amt_q <= cur_bal && !xfer_sum[BAL_W]) begin
                            wr0_en    = 1'b1;
                            wr0_bal   = cur_bal - amt_q;
                            wr1_en    = 1'b1;
                            success_d = 1'b1;
                        end
                    end
                    OP_LOGOUT: begin
                        success_d = 1'b1;
                        state_d   = ST_WAITING;
                    end
                    default: ;
                endcase
            end

            default: state_d = ST_IDLE;
        endcase

        // Forward the write so balance shows the new value alongside done.
        bal_d = wr0_en ? wr0_bal : rd_bal[sess_d];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sess_q    <= '0;
            pin_q     <= '0;
            op_q      <= '0;
            amt_q     <= '0;
            dest_q    <= '0;
            new_pin_q <= '0;
            idle_q    <= '0;
            done      <= 1'b0;
            success   <= 1'b0;
            balance   <= '0;
        end else begin
            sess_q  <= sess_d;
            idle_q  <= idle_d;
            done    <= done_d;
            success <= success_d;
            balance <= bal_d;
            if (state_q == ST_WAITING && start) pin_q <= pin;
            if (state_q == ST_MENU && op_valid) begin
                op_q      <= operation;
                amt_q     <= amount;
                dest_q    <= dest_acc;
                new_pin_q <= new_pin;
            end
        end
    end

    assign state  = state_q;
    assign locked = rd_lock[sess_q];

endmodule
